// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit cells.
package timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One BCD digit step down; zero reloads to the digit's wrap value.
  function automatic logic [DIGIT_W-1:0] bcd_dec(input logic [DIGIT_W-1:0] d,
                                                 input logic [DIGIT_W-1:0] wrap);
    return (d == '0) ? wrap : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with shift-load, clear and borrow-out.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] WRAP = BCD_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic [DIGIT_W-1:0] shift_in,
  input  logic               dec,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out,
  output logic               is_zero
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (shift) begin
      digit_d = shift_in;
    end else if (dec) begin
      digit_d = bcd_dec(digit_q, WRAP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign is_zero    = (digit_q == '0);
  assign borrow_out = dec & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS style BCD countdown timer: keypad shift-in, start/pause/cancel FSM,
// countdown on an external 1 Hz tick with a one-cycle done pulse.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS    = 2,
  parameter int SEC_TENS_WRAP = 5
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic [DIGIT_W-1:0]          data_in,
  input  logic                        loadn,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        tick,
  output logic [DIGIT_W-1:0]          sec_ones,
  output logic [DIGIT_W-1:0]          sec_tens,
  output logic [DIGIT_W*MIN_DIGITS-1:0] mins,
  output logic                        zero,
  output logic                        running,
  output logic                        done,
  output state_t                      state_dbg
);

  localparam int NDIG = MIN_DIGITS + 2;

  // Digit 0 is seconds ones, digit 1 seconds tens, digits 2.. are minutes.
  logic [NDIG-1:0][DIGIT_W-1:0] digits;
  logic [NDIG-1:0]              dig_zero;

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   clr_req, shift, tick_dec, underflow, clr_all;
  logic   key_valid, one_left;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [DIGIT_W-1:0] WRAP_V = (i == 1) ? 4'(SEC_TENS_WRAP) : BCD_MAX;
    logic [DIGIT_W-1:0] sin;
    logic               din;
    logic               bo;
    if (i == 0) begin : g_lsd
      assign sin = data_in;
      assign din = tick_dec;
    end else begin : g_upper
      assign sin = digits[i-1];
      assign din = g_dig[i-1].bo;
    end
    bcd_digit_down #(.WRAP(WRAP_V)) u_digit (
      .clk       (clock),
      .rst       (clear),
      .shift     (shift),
      .shift_in  (sin),
      .dec       (din),
      .clr       (clr_all),
      .digit     (digits[i]),
      .borrow_out(bo),
      .is_zero   (dig_zero[i])
    );
  end

  // A borrow out of the top digit can only come from decrementing zero;
  // clear instead of wrapping to the maximum setting.
  assign underflow = g_dig[NDIG-1].bo;
  assign clr_all   = clr_req | underflow;

  assign zero      = &dig_zero;
  assign one_left  = (digits[0] == 4'd1) && (&dig_zero[NDIG-1:1]);
  assign key_valid = !loadn && (data_in <= BCD_MAX);

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    clr_req  = 1'b0;
    shift    = 1'b0;
    tick_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop) begin
          clr_req = 1'b1;
        end else if (start) begin
          if (!zero) state_d = RUN;
        end else if (key_valid) begin
          shift = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (!start && tick) begin
          tick_dec = 1'b1;
          if (one_left) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          clr_req = 1'b1;
        end else if (start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stop || start) begin
          state_d = IDLE;
        end else if (key_valid) begin
          shift   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign sec_ones  = digits[0];
  assign sec_tens  = digits[1];
  assign mins      = digits[NDIG-1:2];
  assign running   = (state_q == RUN);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (MIN_DIGITS=2): vector table plus
// hand-written countdown and async-clear sequences.
module tb_bcd_countdown_timer;
  import timer_pkg::*;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] data_in = 4'd0;
  logic       loadn = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] sec_ones, sec_tens;
  logic [7:0] mins;
  logic       zero, running, done;
  state_t     state_dbg;

  int checks = 0;
  int failures = 0;

  bcd_countdown_timer #(.MIN_DIGITS(2), .SEC_TENS_WRAP(5)) dut (
    .clock    (clock),
    .clear    (clear),
    .data_in  (data_in),
    .loadn    (loadn),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
    .zero     (zero),
    .running  (running),
    .done     (done),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ld;
    logic [3:0] d;
    logic       st;
    logic       sp;
    logic       tk;
    logic [7:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       run;
    logic       zr;
    logic       dn;
    state_t     s;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic [3:0] d, input logic st,
                              input logic sp, input logic tk, input logic [7:0] m,
                              input logic [3:0] t, input logic [3:0] o, input logic run,
                              input logic zr, input logic dn, input state_t s);
    vec_t v;
    v.ld = ld; v.d = d; v.st = st; v.sp = sp; v.tk = tk;
    v.m = m; v.t = t; v.o = o; v.run = run; v.zr = zr; v.dn = dn; v.s = s;
    return v;
  endfunction

  function automatic logic [31:0] pack_exp(input logic [7:0] m, input logic [3:0] t,
                                           input logic [3:0] o, input logic run,
                                           input logic zr, input logic dn);
    return {13'd0, m, t, o, run, zr, dn};
  endfunction

  function automatic logic [31:0] pack_act();
    return {13'd0, mins, sec_tens, sec_ones, running, zero, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic ld, input logic [3:0] d, input logic st,
                      input logic sp, input logic tk);
    loadn = ~ld; data_in = d; start = st; stop = sp; tick = tk;
    @(posedge clock);
    #1;
    loadn = 1'b1; data_in = 4'd0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int done_cnt;
    int run_drop;

    // {ld,d,st,sp,tk} -> {mins,tens,ones,running,zero,done,state}
    vecs.push_back(mk(1, 4'h9, 0, 0, 0, 8'h00, 4'h0, 4'h9, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h9, 0, 0, 0, 8'h00, 4'h9, 4'h9, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h5, 0, 0, 0, 8'h09, 4'h9, 4'h5, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h9, 0, 0, 0, 8'h99, 4'h5, 4'h9, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h7, 0, 0, 0, 8'h95, 4'h9, 4'h7, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'hA, 0, 0, 0, 8'h95, 4'h9, 4'h7, 0, 0, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, IDLE));
    vecs.push_back(mk(1, 4'h2, 0, 0, 0, 8'h00, 4'h0, 4'h2, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 8'h00, 4'h2, 4'h0, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 8'h02, 4'h0, 4'h0, 0, 0, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h02, 4'h0, 4'h0, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h01, 4'h5, 4'h9, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h01, 4'h5, 4'h9, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h01, 4'h5, 4'h9, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h01, 4'h5, 4'h9, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h01, 4'h5, 4'h9, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h01, 4'h5, 4'h9, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h01, 4'h5, 4'h8, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 8'h01, 4'h5, 4'h8, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h01, 4'h5, 4'h8, 1, 0, 0, RUN));
    vecs.push_back(mk(1, 4'h3, 0, 0, 0, 8'h01, 4'h5, 4'h8, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h01, 4'h5, 4'h8, 0, 0, 0, PAUSE));
    vecs.push_back(mk(1, 4'h3, 0, 0, 0, 8'h01, 4'h5, 4'h8, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, IDLE));
    vecs.push_back(mk(1, 4'h5, 0, 0, 0, 8'h00, 4'h0, 4'h5, 0, 0, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 4'h5, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 1, 1, 8'h00, 4'h0, 4'h5, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, IDLE));
    vecs.push_back(mk(1, 4'h1, 0, 0, 0, 8'h00, 4'h0, 4'h1, 0, 0, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 4'h1, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 4'h0, 4'h0, 0, 1, 1, DONE));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, DONE));
    vecs.push_back(mk(1, 4'h4, 0, 0, 0, 8'h00, 4'h0, 4'h4, 0, 0, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 4'h4, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 4'h0, 4'h3, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 4'h0, 4'h2, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 4'h0, 4'h1, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 4'h0, 4'h0, 0, 1, 1, DONE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, IDLE));
    vecs.push_back(mk(1, 4'h9, 0, 0, 0, 8'h00, 4'h0, 4'h9, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 8'h00, 4'h9, 4'h0, 0, 0, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 4'h9, 4'h0, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 4'h8, 4'h9, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 4'h8, 4'h9, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, IDLE));
    vecs.push_back(mk(1, 4'h1, 0, 0, 0, 8'h00, 4'h0, 4'h1, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 8'h00, 4'h1, 4'h0, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 8'h01, 4'h0, 4'h0, 0, 0, 0, IDLE));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 8'h10, 4'h0, 4'h0, 0, 0, 0, IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 8'h10, 4'h0, 4'h0, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 8'h09, 4'h5, 4'h9, 1, 0, 0, RUN));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h09, 4'h5, 4'h9, 0, 0, 0, PAUSE));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0, 1, 0, IDLE));

    // Reset state while clear is still held.
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", pack_act(), pack_exp(8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0));
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    clear = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].sp, vecs[i].tk);
      check($sformatf("vec%0d_out", i), pack_act(),
            pack_exp(vecs[i].m, vecs[i].t, vecs[i].o, vecs[i].run, vecs[i].zr, vecs[i].dn));
      check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].s));
    end

    // 1:30 counts down in exactly 90 ticks; a tick on the start cycle is not counted.
    key(4'h1); key(4'h3); key(4'h0);
    check("key130", pack_act(), pack_exp(8'h01, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    check("start_tick_ignored", pack_act(), pack_exp(8'h01, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0));
    done_cnt = 0;
    run_drop = 0;
    for (int i = 1; i <= 90; i++) begin
      idle();
      if (done) done_cnt++;
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      if (done) done_cnt++;
      if (i < 90 && !running) run_drop++;
      if (i == 30) check("t30", pack_act(), pack_exp(8'h01, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0));
      if (i == 31) check("t31", pack_act(), pack_exp(8'h00, 4'h5, 4'h9, 1'b1, 1'b0, 1'b0));
      if (i == 89) check("t89", pack_act(), pack_exp(8'h00, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0));
      if (i == 90) begin
        check("t90", pack_act(), pack_exp(8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1));
        check("t90_state", 32'(state_dbg), 32'(DONE));
      end
    end
    repeat (3) begin
      idle();
      if (done) done_cnt++;
    end
    check("done_pulse_count", 32'(done_cnt), 32'd1);
    check("running_held", 32'(run_drop), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("done_stop_idle", 32'(state_dbg), 32'(IDLE));

    // Asynchronous clear in the middle of a count.
    key(4'h1); key(4'h0); key(4'h0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("t10_of_100", pack_act(), pack_exp(8'h00, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0));
    clear = 1'b1;
    #2;
    check("async_clear", pack_act(), pack_exp(8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0));
    check("async_clear_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clock);
    #1;
    clear = 1'b0;
    done_cnt = 0;
    repeat (5) begin
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      if (done || running) done_cnt++;
    end
    check("post_clear_quiet", 32'(done_cnt), 32'd0);
    check("post_clear_out", pack_act(), pack_exp(8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
